packet_disassembler: RTL

Receive-side counterpart of the HDMI data-island packet path. It sits after the TERC4 decoder on the three TMDS channels. Over each 32-clock data-island packet it deserializes the 24-bit header and the four 56-bit subpackets, and checks the BCH parity of each. It then presents one complete packet per `packet_valid` pulse to the InfoFrame/audio consumers.

---
 rtl/hdmi_pkg.sv | 19 +
 rtl/packet_disassembler_bch_lfsr_check.sv | 49 ++++
 rtl/packet_disassembler.sv | 110 +++++++++++
 3 files changed

// File: rtl/hdmi_pkg.sv
// Shared HDMI data-island packet types and the serial BCH parity step
// (also used by packet_assembler on the transmit side).
package hdmi_pkg;

  localparam int         PKT_LEN  = 32;
  localparam int         POS_W    = $clog2(PKT_LEN);
  localparam logic [7:0] BCH_POLY = 8'h83;

  typedef struct packed {
    logic [23:0]      header;
    logic [3:0][55:0] sub;
  } hdmi_packet_t;

  // One LFSR step of x^8+x^7+x^6+1, bits consumed LSB first.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic din);
    return (ecc >> 1) ^ ((ecc[0] ^ din) ? BCH_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/packet_disassembler_bch_lfsr_check.sv
// One packet lane: captures BPC bits per packet clock (LSB first) and runs the BCH LFSR over the data bits.
// data_o/ecc_ok_o are combinational and describe the whole packet on its final clock; no backpressure.
module bch_lfsr_check #(
  parameter int BPC      = 1,
  parameter int DATA_LEN = 24
) (
  input  logic                       clk_pixel,
  input  logic                       reset,
  input  logic                       en_i,
  input  logic [hdmi_pkg::POS_W-1:0] pos_i,
  input  logic [BPC-1:0]             bits_i,
  output logic [DATA_LEN-1:0]        data_o,
  output logic                       ecc_ok_o
);
  import hdmi_pkg::*;

  localparam int W  = DATA_LEN + 8;
  localparam int IW = $clog2(W);

  logic [W-1:0] word_q, word_d;
  logic [7:0]   ecc_q, ecc_d;

  always_comb begin
    word_d = word_q;
    ecc_d  = ecc_q;
    if (en_i) begin
      if (pos_i == '0) ecc_d = 8'h00;
      for (int b = 0; b < BPC; b++) begin
        word_d[IW'(int'(pos_i) * BPC + b)] = bits_i[b];
        // Bits past the data field are the received parity, not LFSR input.
        if (int'(pos_i) * BPC + b < DATA_LEN) ecc_d = bch_step(ecc_d, bits_i[b]);
      end
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      ecc_q  <= '0;
    end else begin
      word_q <= word_d;
      ecc_q  <= ecc_d;
    end
  end

  assign data_o   = word_d[DATA_LEN-1:0];
  assign ecc_ok_o = (ecc_d == word_d[W-1 -: 8]);

endmodule

// File: rtl/packet_disassembler.sv
// HDMI data-island receive path: deserializes header + four subpackets, checks BCH parity and framing.
// packet_valid pulses 1 cycle after packet clock 31 (32 after clock 0); no backpressure, take each packet on its pulse.
module packet_disassembler #(
  parameter int PKT_LEN = 32
) (
  input  logic             clk_pixel,
  input  logic             reset,
  input  logic             data_island_period,
  input  logic [3:0]       ch0_nibble,
  input  logic [3:0]       ch1_nibble,
  input  logic [3:0]       ch2_nibble,
  output logic [23:0]      header,
  output logic [3:0][55:0] sub,
  output logic             packet_valid,
  output logic             header_ecc_ok,
  output logic [3:0]       sub_ecc_ok,
  output logic             framing_ok
);
  import hdmi_pkg::*;

  logic [POS_W-1:0] pos_q, pos_d;
  logic             frame_err_q, frame_err_d;
  logic             done;

  logic [23:0]      hdr_data;
  logic             hdr_ok;
  logic [55:0]      sub_data [4];
  logic             sub_ok   [4];

  hdmi_packet_t     pkt_d, pkt_q;
  logic [3:0]       sub_ok_d, sub_ok_q;
  logic             pv_q, hdr_ok_q, fok_q;

  logic             unused_sync;
  assign unused_sync = ^ch0_nibble[1:0];

  assign done = data_island_period && (pos_q == POS_W'(PKT_LEN - 1));

  always_comb begin
    pos_d       = data_island_period ? pos_q + 1'b1 : '0;
    frame_err_d = frame_err_q;
    if (data_island_period) begin
      if (pos_q == '0) frame_err_d = ch0_nibble[3];
      else             frame_err_d = frame_err_q | ~ch0_nibble[3];
    end
  end

  bch_lfsr_check #(.BPC(1), .DATA_LEN(24)) u_hdr (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .en_i      (data_island_period),
    .pos_i     (pos_q),
    .bits_i    (ch0_nibble[2]),
    .data_o    (hdr_data),
    .ecc_ok_o  (hdr_ok)
  );

  for (genvar k = 0; k < 4; k++) begin : g_sub
    bch_lfsr_check #(.BPC(2), .DATA_LEN(56)) u_sub (
      .clk_pixel (clk_pixel),
      .reset     (reset),
      .en_i      (data_island_period),
      .pos_i     (pos_q),
      .bits_i    ({ch2_nibble[k], ch1_nibble[k]}),
      .data_o    (sub_data[k]),
      .ecc_ok_o  (sub_ok[k])
    );
  end

  always_comb begin
    pkt_d.header = hdr_data;
    pkt_d.sub    = '0;
    sub_ok_d     = '0;
    for (int k = 0; k < 4; k++) begin
      pkt_d.sub[k] = sub_data[k];
      sub_ok_d[k]  = sub_ok[k];
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      pos_q       <= '0;
      frame_err_q <= 1'b0;
      pkt_q       <= '0;
      pv_q        <= 1'b0;
      hdr_ok_q    <= 1'b0;
      sub_ok_q    <= '0;
      fok_q       <= 1'b0;
    end else begin
      pos_q       <= pos_d;
      frame_err_q <= frame_err_d;
      pv_q        <= done;
      // Outputs only move on a complete packet; truncated packets leave them untouched.
      if (done) begin
        pkt_q    <= pkt_d;
        hdr_ok_q <= hdr_ok;
        sub_ok_q <= sub_ok_d;
        fok_q    <= ~frame_err_d;
      end
    end
  end

  assign header        = pkt_q.header;
  assign sub           = pkt_q.sub;
  assign packet_valid  = pv_q;
  assign header_ecc_ok = hdr_ok_q;
  assign sub_ecc_ok    = sub_ok_q;
  assign framing_ok    = fok_q;

endmodule
